// File: rtl/result_stage_pkg.sv
// Shared processor codes for result source selection and memory access size.
package result_stage_pkg;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_LINK = 2'd2,
        SEL_RSVD = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_WORD3 = 2'd3
    } size_e;

endpackage

// File: rtl/result_extend.sv
// Combinational source select and memory load extension for one result.
module result_extend
    import result_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic [1:0]              sel,
    input  logic signed [WIDTH-1:0] alu,
    input  logic signed [WIDTH-1:0] mem,
    input  logic signed [WIDTH-1:0] link,
    input  logic [1:0]              size,
    input  logic                    sext,
    input  logic [RD_W-1:0]         rd,
    output logic [WIDTH-1:0]        data
);

    logic [WIDTH-1:0] mem_ext;

    always_comb begin
        mem_ext = '0;
        case (size_e'(size))
            SZ_BYTE: mem_ext = {{(WIDTH-8){sext & mem[7]}}, mem[7:0]};
            SZ_HALF: mem_ext = {{(WIDTH-16){sext & mem[15]}}, mem[15:0]};
            default: mem_ext = mem;
        endcase
    end

    always_comb begin
        data = '0;
        case (sel_e'(sel))
            SEL_ALU:  data = alu;
            SEL_MEM:  data = mem_ext;
            SEL_LINK: data = link;
            default:  data = '0;
        endcase
        // register zero is hard-wired, whatever the source
        if (rd == '0)
            data = '0;
    end

endmodule

// File: rtl/result_stage.sv
// Result buffer between execute and register-file write: select/extend, then FIFO.
module result_stage
    import result_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int RD_W  = 5,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_sel,
    input  logic signed [WIDTH-1:0] in_alu,
    input  logic signed [WIDTH-1:0] in_mem,
    input  logic signed [WIDTH-1:0] in_link,
    input  logic [1:0]              in_size,
    input  logic                    in_signed,
    input  logic [RD_W-1:0]         in_rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [RD_W-1:0]         out_rd,
    output logic [CW-1:0]           count
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [RD_W-1:0]  rd_q   [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] ext_data;
    logic             push, pop;

    result_extend #(.WIDTH(WIDTH), .RD_W(RD_W)) u_ext (
        .sel  (in_sel),
        .alu  (in_alu),
        .mem  (in_mem),
        .link (in_link),
        .size (in_size),
        .sext (in_signed),
        .rd   (in_rd),
        .data (ext_data)
    );

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? data_q[rd_ptr] : '0;
    assign out_rd    = out_valid ? rd_q[rd_ptr]   : '0;

    // storage is not reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= ext_data;
            rd_q[wr_ptr]   <= in_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/result_stage.md
RESULT_STAGE -- requirements
Module: result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, result datapath width in bits (>= 16).
REQ-002 SHALL have parameter DEPTH, default 4, result buffer entries (>= 2, need not be power of two).
REQ-003 SHALL have parameter RD_W, default 5, destination register index width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  producer offers a result.
REQ-006 SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-007 SHALL have port in_sel  input  2  source select: 0 ALU, 1 MEM, 2 LINK, 3 reserved.
REQ-008 SHALL have ports in_alu, in_mem, in_link  input  WIDTH each  signed candidate results.
REQ-009 SHALL have port in_size  input  2  MEM access size: 0 byte, 1 half, 2/3 word.
REQ-010 SHALL have port in_signed  input  1  MEM extension mode: 1 sign-extend, 0 zero-extend.
REQ-011 SHALL have port in_rd  input  RD_W  destination register index.
REQ-012 SHALL have port out_valid  output  1  buffered result available.
REQ-013 SHALL have port out_ready  input  1  register file consumes the head result.
REQ-014 SHALL have ports out_data  output  WIDTH (signed)  and out_rd  output  RD_W  head result and destination.
REQ-015 SHALL have port count  output  clog2(DEPTH+1)  current occupancy.

Function
REQ-016 SHALL accept (push) a result on a rising edge iff in_valid && in_ready.
REQ-017 SHALL consume (pop) the head entry on a rising edge iff out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count < DEPTH), combinationally from count only; no bypass when full.
REQ-019 SHALL drive out_valid = (count != 0); out_data/out_rd = head entry when valid, all-zero when empty.
REQ-020 SHALL form the stored value by in_sel: ALU -> in_alu; LINK -> in_link; reserved -> 0.
REQ-021 SHALL, for MEM, take in_mem[7:0] (byte) or in_mem[15:0] (half), extended to WIDTH per in_signed; word passes in_mem unchanged.
REQ-022 SHALL store data 0 when in_rd == 0, regardless of source (register zero hard-wired).
REQ-023 SHALL have latency 1: a result pushed into an empty stage appears on out_* the next cycle.
REQ-024 SHALL preserve FIFO order; write and read pointers advance by one per push/pop, wrapping from DEPTH-1 to 0.
REQ-025 SHALL keep count unchanged on simultaneous push and pop (possible only when 0 < count < DEPTH); count +1 on push only, -1 on pop only.
REQ-026 SHALL ignore in_valid while full and out_ready while empty; no state change, no error.
REQ-027 SHALL hold out_data/out_rd stable while out_valid && !out_ready.

Reset
REQ-028 SHALL, on rst_n low, immediately clear count, both pointers, out_valid (0), out_data/out_rd (0); in_ready reads 1.
REQ-029 SHALL discard all buffered results when reset asserts mid-operation; storage array need not be reset.
REQ-030 SHALL release reset synchronously to clk (external synchroniser); first push permitted on the first edge after release.

Structure
REQ-031 SHALL take source-select codes (ALU/MEM/LINK/reserved) and size codes (byte/half/word) from the shared processor package.
REQ-032 SHALL implement extension/select in one combinational sub-module result_extend; storage and pointers live in result_stage.

Verification
REQ-033 SHALL cover: reset, push in_sel=0, in_alu=32'h0000_1234, in_rd=3 -> next cycle out_valid=1, out_data=32'h0000_1234, out_rd=3.
REQ-034 SHALL cover: in_sel=1, in_size=0, in_mem=32'h0000_0080, in_signed=1 -> 32'hFFFF_FF80; in_signed=0 -> 32'h0000_0080; half 16'h8001 signed -> 32'hFFFF_8001.
REQ-035 SHALL cover: in_rd=0, in_alu=32'hDEAD_BEEF -> out_data=0, out_rd=0.
REQ-036 SHALL cover: out_ready=0, push 5 results with DEPTH=4 -> count=4, in_ready=0, 5th dropped; then drain -> first four in order, count=0.
REQ-037 SHALL cover: count=2, push and pop same cycle for 10 cycles -> count stays 2, order preserved across pointer wrap.
REQ-038 SHALL cover: count=3, rst_n low mid-cycle -> count=0, out_valid=0 immediately, before next clk edge.
